// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Drives the sel lines of a 4:1 mux through a masked, ascending,
//               non-wrapping scan. Each enabled channel gets a programmable
//               settle time before its mux output is captured into sample[].
//               Start/busy/done handshake toward the requesting host logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,   // 0..15, counter is 4 bits
    parameter int SEL_BIT_SWAP  = 1    // 1: sel = {ch[0], ch[1]}; 0: sel = ch
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] sample_q, sample_d;

    logic [1:0] w_first_ch;
    logic [1:0] w_next_ch;
    logic       w_next_found;

    // The mux decodes sel[1] as the channel LSB in the swapped wiring.
    function automatic logic [1:0] sel_of(input logic [1:0] ch);
        if (SEL_BIT_SWAP != 0) begin
            return {ch[0], ch[1]};
        end
        return ch;
    endfunction

    // Lowest set bit of the incoming mask, and lowest latched-mask bit above ch.
    // Iterating downward leaves the lowest qualifying index as the final value.
    always_comb begin
        w_first_ch   = 2'd0;
        w_next_ch    = 2'd0;
        w_next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                w_first_ch = 2'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                w_next_ch    = 2'(i);
                w_next_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sample_d = sample_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (mask != 4'd0) begin
                        mask_d   = mask;
                        ch_d     = w_first_ch;
                        sel_d    = sel_of(w_first_ch);
                        cnt_d    = C_SETTLE;
                        // Disabled channels must read 0 after the scan.
                        sample_d = sample_q & mask;
                        busy_d   = 1'b1;
                        state_d  = S_SETTLE;
                    end else begin
                        sample_d = 4'd0;
                        done_d   = 1'b1;
                        state_d  = S_FINISH;
                    end
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_CAPTURE: begin
                // Abort wins over a capture on the same edge.
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    sample_d[ch_q] = mux_out;
                    if (w_next_found) begin
                        ch_d    = w_next_ch;
                        sel_d   = sel_of(w_next_ch);
                        cnt_d   = C_SETTLE;
                        state_d = S_SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 4'd0;
            mask_q   <= 4'd0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
        end
    end

    assign sel    = sel_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sequencer
// Description : Directed self-checking bench for mux_scan_sequencer. Two DUTs
//               share stimulus: one with swapped sel bits feeding a mux that
//               decodes sel[1] as channel LSB, one unswapped with the mux sel
//               bits crossed back to a straight decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] mask;
    logic [3:0] data;

    logic       mux_out_a, mux_out_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [3:0] sample_a, sample_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Mux models: A decodes sel[1] as channel LSB, B decodes sel directly.
    assign mux_out_a = data[{sel_a[0], sel_a[1]}];
    assign mux_out_b = data[sel_b];

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .SEL_BIT_SWAP(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mask(mask),
        .mux_out(mux_out_a), .sel(sel_a), .busy(busy_a), .done(done_a),
        .sample(sample_a)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .SEL_BIT_SWAP(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mask(mask),
        .mux_out(mux_out_b), .sel(sel_b), .busy(busy_b), .done(done_b),
        .sample(sample_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 4-channel scan with data=1010, optionally disturbed mid-scan by a
    // start re-pulse and a mask change that must both be ignored.
    task automatic run_full(input bit disturb);
        logic [1:0] ch;
        data  = 4'b1010;
        mask  = 4'b1111;
        start = 1'b1;
        tick();                       // edge t0 accepts start; now cycle t0+1
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            ch = (k <= 16) ? 2'((k - 1) / 4) : 2'd3;
            check("full_busy", 32'(busy_a), 32'(k <= 16));
            check("full_done", 32'(done_a), 32'(k == 17));
            check("full_sel_swap", 32'(sel_a), 32'({ch[0], ch[1]}));
            check("full_sel_noswap", 32'(sel_b), 32'(ch));
            if (disturb && (k == 5 || k == 10)) begin
                start = 1'b1;
                mask  = 4'b0001;
            end else begin
                start = 1'b0;
                mask  = 4'b1111;
            end
            tick();
        end
        start = 1'b0;
        check("full_done_after", 32'(done_a), 32'd0);
        check("full_sample_swap", 32'(sample_a), 32'b1010);
        check("full_sample_noswap", 32'(sample_b), 32'b1010);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mask  = 4'd0;
        data  = 4'd0;
        tick();
        tick();
        check("rst_sel", 32'(sel_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_sample", 32'(sample_a), 32'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: full scan, both sel orderings.
        run_full(1'b0);
        tick();

        // Scenario 2: mask 0101, data 1111; only channels 0 and 2 visited.
        data  = 4'b1111;
        mask  = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check("m5_busy", 32'(busy_a), 32'(k <= 8));
            check("m5_done", 32'(done_a), 32'(k == 9));
            if (k <= 8) check("m5_sel", 32'(sel_a), (k <= 4) ? 32'b00 : 32'b01);
            tick();
        end
        check("m5_sample", 32'(sample_a), 32'b0101);
        tick();

        // Scenario 3: empty mask completes immediately with sample cleared.
        mask  = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m0_done", 32'(done_a), 32'd1);
        check("m0_busy", 32'(busy_a), 32'd0);
        check("m0_sample", 32'(sample_a), 32'd0);
        tick();
        check("m0_done_once", 32'(done_a), 32'd0);
        check("m0_busy_after", 32'(busy_a), 32'd0);

        // Scenario 4: abort during SETTLE of channel 2 (cycles t0+9..t0+11).
        data  = 4'b1111;
        mask  = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("ab_busy_before", 32'(busy_a), 32'd1);
        check("ab_sel_ch2", 32'(sel_a), 32'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy_a), 32'd0);
        check("ab_done", 32'(done_a), 32'd0);
        check("ab_sample", 32'(sample_a), 32'b0011);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("ab_no_done", 32'(done_a), 32'd0);
        end
        check("ab_sample_kept", 32'(sample_a), 32'b0011);

        // Scenario 5: start re-pulse and mask change mid-scan are ignored.
        run_full(1'b1);
        tick();

        // Scenario 6: reset during CAPTURE of channel 1 (cycle t0+8).
        data  = 4'b1010;
        mask  = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        check("rc_sel_before", 32'(sel_a), 32'b10);
        check("rc_sample_before", 32'(sample_a), 32'b1010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rc_sel", 32'(sel_a), 32'd0);
        check("rc_busy", 32'(busy_a), 32'd0);
        check("rc_done", 32'(done_a), 32'd0);
        check("rc_sample", 32'(sample_a), 32'd0);
        tick();
        check("rc_idle_done", 32'(done_a), 32'd0);
        run_full(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 4:1 mux (`Mux4to1`): drives the mux `sel` lines through a masked round-robin scan of the four data channels.
- Waits a programmable settle time on each channel, then samples the mux output into a 4-bit result register.
- Start/busy/done handshake toward the host logic that requests a scan.

Parameters:
- SETTLE_CYCLES, 2, wait cycles after a `sel` change before sampling; legal range 0..15; counter is 4 bits.
- SEL_BIT_SWAP, 1, mux sel bit order. 1: `sel = {ch[0], ch[1]}`, because the mux decodes `sel[1]` as channel LSB. 0: `sel = ch`.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  scan request, sampled only in IDLE
- abort  input  1  cancels an active scan
- mask  input  4  channel enable, bit i = data channel i; latched on start accept
- mux_out  input  1  output of the 4:1 mux
- sel  output  2  registered select to the mux
- busy  output  1  high in SETTLE/CAPTURE
- done  output  1  one-cycle pulse in FINISH
- sample  output  4  registered captured values, bit i = channel i

Behaviour:
- All outputs are registered. Reset takes priority over every other input.
- Reset values: state=IDLE, `sel=0`, `busy=0`, `done=0`, `sample=0`, internal channel and counter regs 0.
- States: IDLE, SETTLE, CAPTURE, FINISH.
- IDLE:
  - `start=1`, `mask!=0`: latch mask; ch = lowest set bit; drive sel for ch; cnt=SETTLE_CYCLES; clear sample bits whose mask bit is 0; -> SETTLE.
  - `start=1`, `mask=0`: `sample=0`; -> FINISH.
- SETTLE: `cnt==0` -> CAPTURE; else cnt--. Lasts SETTLE_CYCLES+1 cycles.
- CAPTURE:
  - `sample[ch] <= mux_out`.
  - Next = lowest latched-mask bit above ch. If it exists: ch=next, update sel, reload cnt, -> SETTLE. Else -> FINISH.
- FINISH: `done=1` for exactly this cycle, `busy=0`; -> IDLE.
- Latency: start accepted at edge t0; busy rises at t0+1; each enabled channel costs SETTLE_CYCLES+2 cycles; done is high in cycle t0 + 1 + k*(SETTLE_CYCLES+2) for k enabled channels.
- Scan order is ascending channel index and never wraps. Disabled channels are skipped with zero cycles spent and their sample bits read 0 after the scan.
- `start` while busy or in FINISH: ignored; no queueing.
- `mask` changes during a scan: no effect; the latched copy is used.
- `abort` in SETTLE/CAPTURE: -> IDLE next edge, no done pulse, `busy=0`. Bits captured before the abort are kept. Uncaptured enabled bits keep their old values.
- Simultaneous `abort` and a CAPTURE edge: abort wins; no capture that cycle.
- `abort` in IDLE/FINISH: ignored.
- `sel` holds its last value in IDLE and FINISH.
- Reset mid-scan: immediate return to reset values at that edge; no done.

Test Plan:
- Mux model with data=4'b1010, SEL_BIT_SWAP=1, SETTLE_CYCLES=2, mask=4'b1111, start pulse at t0 -> sel sequence 00,10,01,11, each held 4 cycles; busy t0+1..t0+16; done only at t0+17; sample=4'b1010.
- mask=4'b0101, data=4'b1111 -> only channels 0 and 2 visited (sel 00 then 01); done at t0+9; sample=4'b0101.
- mask=0 with start -> done at t0+1; busy never high; sample=0.
- Abort while in SETTLE on channel 2 of a full scan, prior sample=4'b0000, data=4'b1111 -> no done; busy low next cycle; sample=4'b0011.
- start re-pulsed mid-scan, and mask changed mid-scan -> scan timing and results identical to the first scenario.
- rst asserted mid-CAPTURE -> next cycle sel=0, busy=0, done=0, sample=0; a subsequent start scans normally.
- Same as the first scenario with SEL_BIT_SWAP=0 and mux sel bits crossed in the bench -> same sample=4'b1010.
